// File: rtl/ldpc_sys_encoder_if.sv
`timescale 1ns/1ps
// Valid/ready link for ldpc_sys_encoder: K-bit message in, (K+M)-bit codeword out.
interface ldpc_sys_encoder_if #(
  parameter int K = 4,
  parameter int M = 8
);
  // Both channels: a transfer occurs on a rising clk edge where valid and ready are
  // both high; the source holds its data stable while valid is high and ready is low.
  logic         in_valid;
  logic         in_ready;
  logic [K-1:0] in_msg;
  logic           out_valid;
  logic           out_ready;
  logic [K+M-1:0] out_code;

  modport master (
    output in_valid, in_msg, out_ready,
    input  in_ready, out_valid, out_code
  );

  modport slave (
    input  in_valid, in_msg, out_ready,
    output in_ready, out_valid, out_code
  );
endinterface

// File: rtl/ldpc_sys_encoder.sv
`timescale 1ns/1ps
// Systematic LDPC encoder: codeword = {P*msg over GF(2), msg}.
// Define LDPC_ENC_PARALLEL_EN for single-cycle parity; default is serial column accumulation.
module ldpc_sys_encoder #(
  parameter int K = 4,
  parameter int M = 8,
  parameter logic [M*K-1:0] P_MATRIX = 32'hE51EE477
) (
  input  logic              clk,
  input  logic              rst_n,
  ldpc_sys_encoder_if.slave bus,
  output logic              busy,
  output logic [15:0]       enc_cnt,
  output logic [1:0]        state_dbg
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_HOLD = 2'd2} state_t;

  state_t         state, state_nxt;
  logic           accept, load, deliver;
  logic [K-1:0]   msg_r;
  logic [M-1:0]   parity_nxt;
  logic [K+M-1:0] code_r;
  logic           valid_r;

`ifdef LDPC_ENC_PARALLEL_EN
  // Whole parity vector from the captured message in one cycle.
  always_comb begin
    parity_nxt = '0;
    for (int j = 0; j < M; j++) begin
      parity_nxt[j] = ^(P_MATRIX[j*K +: K] & msg_r);
    end
  end

  wire calc_done = 1'b1;
`else
  localparam int CW = $clog2(K);
  localparam logic [CW-1:0] LAST = CW'(K - 1);

  logic [CW-1:0] cnt;
  logic [M-1:0]  acc;
  logic [M-1:0]  col;

  // Column cnt of P is bit cnt of every row.
  always_comb begin
    col = '0;
    for (int j = 0; j < M; j++) begin
      col[j] = P_MATRIX[j*K + int'(cnt)];
    end
    parity_nxt = msg_r[cnt] ? (acc ^ col) : acc;
  end

  wire calc_done = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      acc <= '0;
    end else if (accept) begin
      cnt <= '0;
      acc <= '0;
    end else if (state == S_CALC) begin
      acc <= parity_nxt;
      if (!calc_done) cnt <= cnt + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    load      = 1'b0;
    deliver   = 1'b0;
    case (state)
      S_IDLE: if (bus.in_valid) begin
        accept    = 1'b1;
        state_nxt = S_CALC;
      end
      S_CALC: if (calc_done) begin
        load      = 1'b1;
        state_nxt = S_HOLD;
      end
      S_HOLD: if (bus.out_ready) begin
        deliver   = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msg_r   <= '0;
      code_r  <= '0;
      valid_r <= 1'b0;
      enc_cnt <= '0;
    end else begin
      if (accept) msg_r <= bus.in_msg;
      if (load) begin
        code_r  <= {parity_nxt, msg_r};
        valid_r <= 1'b1;
      end
      if (deliver) begin
        valid_r <= 1'b0;
        enc_cnt <= enc_cnt + 16'd1;
      end
    end
  end

  // in_ready is forced low while reset is held even though the state is IDLE.
  assign bus.in_ready  = rst_n && (state == S_IDLE);
  assign bus.out_valid = valid_r;
  assign bus.out_code  = code_r;
  assign busy          = (state == S_CALC) || (state == S_HOLD);
  assign state_dbg     = state;
endmodule

// File: tb/tb_ldpc_sys_encoder.sv
`timescale 1ns/1ps
// Bench for ldpc_sys_encoder: default (4,8) instance with directed vectors and
// a (8,4) instance swept over all 256 messages against a row-wise GF(2) model.
module tb_ldpc_sys_encoder;
`ifdef LDPC_ENC_PARALLEL_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 4;
`endif
  localparam logic [31:0] P1 = 32'h9C3A_5E71;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          hs_edge0 = 0;
  logic        busy0, busy1;
  logic [15:0] enc_cnt0, enc_cnt1;
  logic [1:0]  st0, st1;
  logic [11:0] exp0_q[$];
  logic [11:0] exp1_q[$];

  ldpc_sys_encoder_if #(.K(4), .M(8)) if0 ();
  ldpc_sys_encoder_if #(.K(8), .M(4)) if1 ();

  ldpc_sys_encoder dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave),
    .busy(busy0), .enc_cnt(enc_cnt0), .state_dbg(st0)
  );

  ldpc_sys_encoder #(.K(8), .M(4), .P_MATRIX(P1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave),
    .busy(busy1), .enc_cnt(enc_cnt1), .state_dbg(st1)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] model1(input logic [7:0] m);
    logic [3:0] p;
    for (int j = 0; j < 4; j++) p[j] = ^(P1[j*8 +: 8] & m);
    return {p, m};
  endfunction

  // ---------------- drivers ----------------
  task automatic send0(input logic [3:0] m, input logic [11:0] e, input bit push,
                       output int acc_edge);
    bit ok = 1'b0;
    if0.in_valid = 1'b1;
    if0.in_msg   = m;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (if0.in_ready) begin ok = 1'b1; break; end
    end
    acc_edge = cyc + 1;
    if (ok && push) exp0_q.push_back(e);
    if (!ok) check("accept0_timeout", 0, 1);
    @(posedge clk); #1;
    if0.in_valid = 1'b0;
  endtask

  task automatic send1(input logic [7:0] m);
    bit ok = 1'b0;
    if1.in_valid = 1'b1;
    if1.in_msg   = m;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (if1.in_ready) begin ok = 1'b1; break; end
    end
    if (ok) exp1_q.push_back(model1(m));
    else    check("accept1_timeout", 0, 1);
    @(posedge clk); #1;
    if1.in_valid = 1'b0;
  endtask

  task automatic wait_valid0();
    bit ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (if0.out_valid) begin ok = 1'b1; break; end
    end
    if (!ok) check("valid0_timeout", 0, 1);
  endtask

  task automatic drain0();
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (exp0_q.size() == 0) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) check("drain0_timeout", exp0_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic drain1();
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (exp1_q.size() == 0) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) check("drain1_timeout", exp1_q.size(), 0);
    @(posedge clk); #1;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [11:0] e;
    if (rst_n && if0.out_valid && if0.out_ready) begin
      hs_edge0 = cyc + 1;
      if (exp0_q.size() == 0) check("code0_unexpected", 1, 0);
      else begin
        e = exp0_q.pop_front();
        check("code0", if0.out_code, e);
      end
    end
    if (rst_n && if1.out_valid && if1.out_ready) begin
      if (exp1_q.size() == 0) check("code1_unexpected", 1, 0);
      else begin
        e = exp1_q.pop_front();
        check("code1", if1.out_code, e);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int a, a2, cnt_before;
    if0.in_valid = 1'b0; if0.in_msg = '0; if0.out_ready = 1'b0;
    if1.in_valid = 1'b0; if1.in_msg = '0; if1.out_ready = 1'b1;

    #12;
    check("rst_in_ready", if0.in_ready, 0);
    check("rst_out_valid", if0.out_valid, 0);
    check("rst_out_code", if0.out_code, 0);
    check("rst_busy", busy0, 0);
    check("rst_enc_cnt", enc_cnt0, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    #1;
    check("idle_in_ready", if0.in_ready, 1);
    check("idle_state", st0, 0);

    // Single word, latency and count
    if0.out_ready = 1'b1;
    send0(4'hB, 12'h60B, 1'b1, a);
    check("busy_after_accept", busy0, 1);
    check("in_ready_after_accept", if0.in_ready, 0);
    wait_valid0();
    check("latency", cyc - a, LAT);
    drain0();
    check("enc_cnt_1", enc_cnt0, 1);

    // Back-to-back: second accept one edge after the first output handshake
    send0(4'hF, 12'hBFF, 1'b1, a);
    send0(4'h0, 12'h000, 1'b1, a2);
    check("b2b_accept_edge", a2, hs_edge0 + 1);
    drain0();
    check("enc_cnt_3", enc_cnt0, 3);

    // Backpressure: output held, input blocked, stray in_valid ignored
    if0.out_ready = 1'b0;
    send0(4'hB, 12'h60B, 1'b1, a);
    wait_valid0();
    if0.in_valid = 1'b1;
    if0.in_msg   = 4'h5;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_code_held", if0.out_code, 12'h60B);
      check("bp_in_ready", if0.in_ready, 0);
    end
    check("bp_enc_cnt", enc_cnt0, 3);
    @(posedge clk); #1;
    if0.in_valid  = 1'b0;
    cnt_before    = enc_cnt0;
    if0.out_ready = 1'b1;
    drain0();
    check("bp_enc_cnt_inc", enc_cnt0, cnt_before + 1);
    check("idle_out_valid", if0.out_valid, 0);
    check("idle_code_kept", if0.out_code, 12'h60B);

    // Reset in the middle of a word
    if0.out_ready = 1'b0;
    send0(4'hF, 12'h000, 1'b0, a);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", if0.out_valid, 0);
    check("midrst_out_code", if0.out_code, 0);
    check("midrst_enc_cnt", enc_cnt0, 0);
    check("midrst_in_ready", if0.in_ready, 0);
    check("midrst_busy", busy0, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("postrst_in_ready", if0.in_ready, 1);
    if0.out_ready = 1'b1;
    send0(4'hB, 12'h60B, 1'b1, a);
    drain0();
    check("postrst_enc_cnt", enc_cnt0, 1);

    // (8,4) instance: every message against the reference model
    for (int m = 0; m < 256; m++) send1(8'(m));
    drain1();
    check("enc_cnt1_256", enc_cnt1, 256);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ldpc_sys_encoder.md
# ldpc_sys_encoder

Parametrised systematic LDPC encoder: accepts a K-bit message over a valid/ready handshake and computes M parity bits as parity = P·msg over GF(2), with P supplied as a parameter. It emits an N=K+M bit codeword {parity, msg} over a valid/ready output handshake. It sits between the UART receive path and the transmit/channel path, and generalises the fixed (12,4) encoder to arbitrary K, M and P with proper flow control.

## Interface
- K, 4, message width in bits (≥2)
- M, 8, parity width in bits (≥1)
- P_MATRIX, 32'hE51EE477, M·K bits; row j (parity bit j) occupies bits [j·K+K-1 : j·K]; bit i of a row multiplies msg[i]
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  message present on in_msg
- in_ready  out  1  encoder can accept a message
- in_msg  in  K  message bits
- out_valid  out  1  codeword valid on out_code
- out_ready  in  1  downstream accepts codeword
- out_code  out  K+M  codeword {parity[M-1:0], msg[K-1:0]}
- busy  out  1  high in CALC or HOLD
- enc_cnt  out  16  count of codewords delivered (out handshakes), wraps 16'hFFFF→0

## Operation
- Parity bit j = XOR over i of (P_MATRIX[j·K+i] & msg[i]).
- FSM states:
  - IDLE: in_ready=1. On in_valid: capture in_msg into msg_r, clear parity accumulator, bit counter ← 0, go to CALC.
  - CALC: each cycle, if msg_r[cnt]=1, XOR column cnt of P (M bits) into the accumulator, then cnt++. The cycle with cnt==K-1 loads out_code ← {acc_next, msg_r} and goes to HOLD.
  - HOLD: out_valid=1; out_code stable. On out_ready: enc_cnt++, go to IDLE.
- in_ready=1 only in IDLE; in_valid in CALC/HOLD is ignored. The message is not consumed, and the source must hold it.
- The bit counter is $clog2(K) bits wide and never exceeds K-1.
- out_code holds its last value after returning to IDLE; it changes only on a load.
- Reset values: in_ready=0 while rst_n low, 1 after release (IDLE); out_valid=0; out_code=0; busy=0; enc_cnt=0; internal msg_r, accumulator and counter=0.
- Reset asserted mid-CALC or mid-HOLD aborts the word: the FSM returns to IDLE, nothing is delivered, and enc_cnt is unchanged from 0.

## Timing
- Accept at rising edge T (in_valid & in_ready). Serial mode: CALC occupies edges T+1..T+K, and out_valid is high from after edge T+K. Latency is K cycles.
- Output handshake at edge X: out_valid low after X, in_ready high after X. Earliest next accept is X+1.
- Minimum period per word is K+2 cycles (serial) with out_ready tied high.
- out_valid and out_code are registered outputs. in_ready and busy decode directly from the state register.

## Configuration
- LDPC_ENC_PARALLEL_EN:
  - Defined: CALC is a single cycle. All M parity bits are computed combinationally from msg_r, and out_code is loaded at edge T+1. Latency is 1 and the minimum word period is 3 cycles.
  - Undefined: the serial K-cycle column accumulation described above.
  - Codeword values and the handshake are identical in both modes; only latency differs.

## Test plan
- Defaults, in_msg=4'hB, out_ready=1 → out_code=12'h60B; out_valid rises K=4 cycles after accept (1 with macro); enc_cnt=1.
- in_msg=4'hF then 4'h0 back-to-back → 12'hBFF then 12'h000; second accept occurs exactly one cycle after the first out handshake.
- Backpressure: out_ready=0 for 10 cycles after out_valid → out_code held, in_ready stays 0, new in_valid ignored; release → one handshake, enc_cnt increments by 1.
- Reset pulse mid-CALC → out_valid=0, out_code=12'h000, enc_cnt=0, in_ready=1 after release; the next message encodes correctly.
- K=8, M=4, random P_MATRIX, 1000 random messages → every out_code matches the reference GF(2) model; after 65536 words enc_cnt wraps to 0.
